// File: rtl/loopback_statii_scheduler.sv
// loopback_statii_scheduler
//   Time-shares one 32-bit status word among N_SRC sources. Pending sources
//   are granted round-robin. Each captured word is tagged with a seen flag, a
//   3-bit sequence number and the source index. It is then held for at least
//   HOLD_CYCLES+1 cycles, so a slow poller on the far side of a clock crossing
//   always reads a coherent value. A freeze level blocks new grants.
//
// Ports
//   user_clk       clock (rising edge)
//   user_rst_n     asynchronous active-low reset
//   src_valid      per-source request, held until src_ack
//   src_data       packed payloads, source i at [i*DATA_W +: DATA_W]
//   src_ack        one-hot, one-cycle capture acknowledge (registered)
//   freeze         level; blocks new grants while high
//   user_data_out  {seen, seq[2:0], idx[3:0], payload[23:0]}
//   busy           high while a captured word is in its hold window
module loopback_statii_scheduler #(
  parameter int N_SRC       = 4,
  parameter int DATA_W      = 24,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ack,
  input  logic                    freeze,
  output logic [31:0]             user_data_out,
  output logic                    busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state;
  logic [7:0] cnt;
  logic [3:0] last;
  logic [2:0] seq;

  // Requests and payloads widened to the full 16-source index space, so the
  // 4-bit grant index selects them without width games. Unused slots read 0.
  logic [15:0]       valid16;
  logic [15:0][23:0] pay;

  assign valid16 = 16'(src_valid);

  for (genvar i = 0; i < 16; i++) begin : g_pay
    if (i < N_SRC) begin : g_used
      assign pay[i] = 24'(src_data[i*DATA_W +: DATA_W]);
    end else begin : g_unused
      assign pay[i] = '0;
    end
  end

  // Round-robin search starting at last+1, wrapping modulo N_SRC. last is
  // always below N_SRC, so a single conditional subtract keeps the candidate
  // in range.
  logic       gnt_found;
  logic [3:0] gnt_idx;
  logic [4:0] sum;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      sum = {1'b0, last} + 5'(k);
      if (sum >= 5'(N_SRC)) sum = sum - 5'(N_SRC);
      if (!gnt_found && valid16[sum[3:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[3:0];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= 4'(N_SRC-1);
      seq           <= '0;
      user_data_out <= '0;
      src_ack       <= '0;
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (!freeze && gnt_found) begin
            user_data_out <= {1'b1, seq + 3'd1, gnt_idx, pay[gnt_idx]};
            seq           <= seq + 3'd1;
            last          <= gnt_idx;
            cnt           <= 8'(HOLD_CYCLES-1);
            state         <= HOLD;
            src_ack       <= {{(N_SRC-1){1'b0}}, 1'b1} << gnt_idx;
          end
        end
        default: begin
          // The hold ends one edge after cnt reaches zero, giving HOLD_CYCLES
          // cycles in HOLD; requests and freeze are ignored meanwhile.
          if (cnt != 8'd0) cnt   <= cnt - 8'd1;
          else             state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_loopback_statii_scheduler.sv
// Directed bench for loopback_statii_scheduler with a queue of expected
// status words; each capture (seen through src_ack) pops and compares.
module tb_loopback_statii_scheduler;
  localparam int N_SRC = 4;
  localparam int DATA_W = 24;
  localparam int HOLD = 16;

  logic                    user_clk = 1'b0;
  logic                    user_rst_n;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ack;
  logic                    freeze;
  logic [31:0]             user_data_out;
  logic                    busy;

  loopback_statii_scheduler #(.N_SRC(N_SRC), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .src_valid(src_valid),
    .src_data(src_data), .src_ack(src_ack), .freeze(freeze),
    .user_data_out(user_data_out), .busy(busy));

  always #5 user_clk = ~user_clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  seq_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] idx, input logic [23:0] d);
    seq_m = seq_m + 3'd1;
    exp_q.push_back({1'b1, seq_m, idx, d});
  endtask

  // Step until src_ack appears (bounded), then pop and compare the word/ack.
  task automatic wait_capture(input string tag, input int budget, output int waited);
    logic        found;
    logic [31:0] e;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      tick();
      waited++;
      if (src_ack != '0) found = 1'b1;
    end
    chk($sformatf("%s_found", tag), 32'(found), 32'd1);
    if (found && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_word", tag), user_data_out, e);
      chk($sformatf("%s_ack", tag), 32'(src_ack), 32'(1) << e[27:24]);
    end
  endtask

  // Counts cycles with busy high, starting from the capture cycle.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk($sformatf("%s_busy_len", tag), 32'(n), 32'(HOLD));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #3 user_rst_n = 1'b0;
    #1;
    chk($sformatf("%s_rst_data", tag), user_data_out, 32'h0);
    chk($sformatf("%s_rst_busy", tag), 32'(busy), 32'h0);
    chk($sformatf("%s_rst_ack", tag), 32'(src_ack), 32'h0);
    repeat (3) @(posedge user_clk);
    #2 user_rst_n = 1'b1;
    seq_m = '0;
    exp_q.delete();
  endtask

  initial begin
    int          w;
    logic        saw_ack;
    logic [31:0] w0;

    user_rst_n = 1'b0;
    src_valid  = '0;
    src_data   = '0;
    freeze     = 1'b0;
    seq_m      = '0;
    #1;
    chk("init_data", user_data_out, 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_ack", 32'(src_ack), 32'h0);
    repeat (2) @(posedge user_clk);
    #2 user_rst_n = 1'b1;
    tick();

    // Single source: src 2 posts ABCDEF.
    src_data[2*DATA_W +: DATA_W] = 24'hABCDEF;
    src_valid = 4'b0100;
    exp_q.push_back(32'h92ABCDEF);
    seq_m = 3'd1;
    wait_capture("single", 5, w);
    chk("single_latency", 32'(w), 32'd1);
    src_valid = '0;
    count_busy("single");
    chk("single_ack_clear", 32'(src_ack), 32'h0);
    chk("single_hold_data", user_data_out, 32'h92ABCDEF);

    // Reset in IDLE; next grants start at source 0.
    do_reset("idle");
    tick();

    // All four requesting, data = index, each drops after its ack.
    for (int i = 0; i < N_SRC; i++) begin
      src_data[i*DATA_W +: DATA_W] = 24'(i);
      push(4'(i), 24'(i));
    end
    src_valid = 4'b1111;
    for (int i = 0; i < N_SRC; i++) begin
      wait_capture($sformatf("rr%0d", i), 40, w);
      chk($sformatf("rr%0d_spacing", i), 32'(w), (i == 0) ? 32'd1 : 32'(HOLD + 1));
      src_valid[i] = 1'b0;
    end
    count_busy("rr_last");

    // Freeze during src 0 hold with src 1 pending.
    push(4'd0, 24'd0);
    push(4'd1, 24'd1);
    w0 = exp_q[0];
    src_valid = 4'b0011;
    wait_capture("frz_src0", 5, w);
    src_valid[0] = 1'b0;
    repeat (3) tick();
    freeze = 1'b1;
    saw_ack = 1'b0;
    repeat (40) begin
      tick();
      if (src_ack != '0) saw_ack = 1'b1;
    end
    chk("frz_no_grant", 32'(saw_ack), 32'h0);
    chk("frz_data_held", user_data_out, w0);
    chk("frz_idle", 32'(busy), 32'h0);
    freeze = 1'b0;
    wait_capture("frz_src1", 5, w);
    chk("frz_release_latency", 32'(w), 32'd1);
    src_valid[1] = 1'b0;
    count_busy("frz_src1");

    // Sequence wrap: nine captures from src 3 after a fresh reset.
    do_reset("wrap");
    src_data[3*DATA_W +: DATA_W] = 24'h0000A3;
    for (int i = 0; i < 9; i++) push(4'd3, 24'h0000A3);
    src_valid = 4'b1000;
    for (int i = 0; i < 9; i++) begin
      wait_capture($sformatf("wrap%0d", i), 40, w);
      chk($sformatf("wrap%0d_spacing", i), 32'(w), (i == 0) ? 32'd1 : 32'(HOLD + 1));
    end

    // Reset mid-HOLD with src 1 pending.
    src_valid = 4'b0010;
    repeat (5) tick();
    chk("midhold_busy", 32'(busy), 32'h1);
    do_reset("midhold");
    chk("midhold_post_data", user_data_out, 32'h0);
    exp_q.push_back(32'h91000001);
    seq_m = 3'd1;
    wait_capture("midhold_src1", 5, w);
    chk("midhold_latency", 32'(w), 32'd1);
    src_valid = '0;
    count_busy("midhold_src1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
